// File: rtl/lut_acc_pkg.sv
// Shared constants and the nibble encoder used by lut_acc_seq: a nonzero nibble
// becomes odd * 2^shift, with the odd part selecting a one-hot LUT row.
package lut_acc_pkg;

    localparam int LUT_WORD_W = 12;
    localparam int SAMPLE_W   = 8;
    localparam int NIB_W      = 4;
    localparam int ADDR_W     = 8;
    localparam int SHIFT_W    = 2;

    typedef struct packed {
        logic [ADDR_W-1:0]  onehot;
        logic [SHIFT_W-1:0] shift;
        logic               zero;
    } nib_code_t;

    function automatic nib_code_t nib_encode(input logic [NIB_W-1:0] n);
        nib_code_t        c;
        logic [NIB_W-1:0] k;
        logic [2:0]       idx;
        c.onehot = '0;
        c.shift  = '0;
        c.zero   = 1'b1;
        k        = '0;
        idx      = '0;
        if (n != '0) begin
            c.zero = 1'b0;
            // Scanning downward leaves the lowest set bit, i.e. the trailing-zero count.
            for (int i = NIB_W - 1; i >= 0; i--) begin
                if (n[i]) c.shift = SHIFT_W'(i);
            end
            k        = n >> c.shift;
            idx      = 3'((k - 4'd1) >> 1);
            c.onehot = 8'b1 << idx;
        end
        return c;
    endfunction

endpackage

// File: rtl/lut_acc_seq_nibble_enc.sv
// Combinational nibble encoder: one-hot odd-multiple LUT address, shift and zero flag.
module nibble_enc
    import lut_acc_pkg::*;
(
    input  logic [NIB_W-1:0]   nib,
    output logic [ADDR_W-1:0]  onehot,
    output logic [SHIFT_W-1:0] shift,
    output logic               zero
);

    nib_code_t code;

    always_comb begin
        code   = nib_encode(nib);
        onehot = code.onehot;
        shift  = code.shift;
        zero   = code.zero;
    end

endmodule

// File: rtl/lut_acc_seq.sv
// lut_acc_seq: two-stage sequencer/accumulator around the odd-multiple coefficient LUT.
// Build option: define LUT_ACC_OVF_EN to add the per-window carry-out flag port ovf.
module lut_acc_seq
    import lut_acc_pkg::*;
#(
    parameter int TAPS  = 8,
    parameter int ACC_W = 24
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [SAMPLE_W-1:0]   in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [ADDR_W-1:0]     address0,
    output logic [ADDR_W-1:0]     address1,
    input  logic [LUT_WORD_W-1:0] memwrd0,
    input  logic [LUT_WORD_W-1:0] memwrd1,
    output logic [ACC_W-1:0]      out_data,
    output logic                  out_valid,
`ifdef LUT_ACC_OVF_EN
    output logic                  ovf,
`endif
    input  logic                  out_ready
);

    localparam int CNT_W = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam int PAD_W = ACC_W - LUT_WORD_W;

    logic [ADDR_W-1:0]  enc0_onehot, enc1_onehot;
    logic [SHIFT_W-1:0] enc0_shift, enc1_shift;
    logic               enc0_zero, enc1_zero;

    nibble_enc u_enc_lo (
        .nib    (in_data[NIB_W-1:0]),
        .onehot (enc0_onehot),
        .shift  (enc0_shift),
        .zero   (enc0_zero)
    );

    nibble_enc u_enc_hi (
        .nib    (in_data[SAMPLE_W-1:NIB_W]),
        .onehot (enc1_onehot),
        .shift  (enc1_shift),
        .zero   (enc1_zero)
    );

    logic [ADDR_W-1:0] addr0_q, addr0_d, addr1_q, addr1_d;
    logic [2:0]        sh0_q, sh0_d, sh1_q, sh1_d;
    logic              zero0_q, zero0_d, zero1_q, zero1_d;
    logic              last_q, last_d;
    logic              valid_a_q, valid_a_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [ACC_W-1:0]  out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;

    logic              stall_b, adv_b, accept, last_in;
    logic [ACC_W-1:0]  term0, term1, sum;

    // Stage B only blocks when it must overwrite an unconsumed result.
    assign stall_b  = valid_a_q && last_q && out_valid_q && !out_ready;
    assign adv_b    = valid_a_q && !stall_b;
    assign in_ready = !valid_a_q || adv_b;
    assign accept   = in_valid && in_ready;
    assign last_in  = (cnt_q == CNT_W'(TAPS - 1));

    // The LUT stores inverted products, so inverting the word recovers the odd multiple.
    always_comb begin
        term0 = '0;
        term1 = '0;
        if (!zero0_q) term0 = {{PAD_W{1'b0}}, ~memwrd0} << sh0_q;
        if (!zero1_q) term1 = {{PAD_W{1'b0}}, ~memwrd1} << sh1_q;
    end

`ifdef LUT_ACC_OVF_EN
    logic [ACC_W:0] sum_a, sum_b;
    logic           carry;
    logic           ovf_acc_q, ovf_acc_d, ovf_q, ovf_d;

    always_comb begin
        sum_a = {1'b0, acc_q} + {1'b0, term0};
        sum_b = {1'b0, sum_a[ACC_W-1:0]} + {1'b0, term1};
        sum   = sum_b[ACC_W-1:0];
        carry = sum_a[ACC_W] | sum_b[ACC_W];
    end

    always_comb begin
        ovf_acc_d = ovf_acc_q;
        ovf_d     = ovf_q;
        if (adv_b) begin
            if (last_q) begin
                ovf_d     = ovf_acc_q | carry;
                ovf_acc_d = 1'b0;
            end else begin
                ovf_acc_d = ovf_acc_q | carry;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_acc_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            ovf_acc_q <= ovf_acc_d;
            ovf_q     <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`else
    always_comb sum = acc_q + term0 + term1;
`endif

    always_comb begin
        addr0_d     = addr0_q;
        addr1_d     = addr1_q;
        sh0_d       = sh0_q;
        sh1_d       = sh1_q;
        zero0_d     = zero0_q;
        zero1_d     = zero1_q;
        last_d      = last_q;
        valid_a_d   = valid_a_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;

        // Stage A: capture encoded nibbles; tap position is tracked at acceptance.
        if (accept) begin
            addr0_d   = enc0_onehot;
            addr1_d   = enc1_onehot;
            sh0_d     = {1'b0, enc0_shift};
            sh1_d     = {1'b0, enc1_shift} + 3'd4;
            zero0_d   = enc0_zero;
            zero1_d   = enc1_zero;
            last_d    = last_in;
            valid_a_d = 1'b1;
            cnt_d     = last_in ? '0 : cnt_q + 1'b1;
        end else if (adv_b) begin
            valid_a_d = 1'b0;
        end

        if (out_valid_q && out_ready) out_valid_d = 1'b0;

        // Stage B: fold both terms; a fresh result overrides a same-cycle handover.
        if (adv_b) begin
            if (last_q) begin
                out_data_d  = sum;
                out_valid_d = 1'b1;
                acc_d       = '0;
            end else begin
                acc_d = sum;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr0_q     <= '0;
            addr1_q     <= '0;
            sh0_q       <= '0;
            sh1_q       <= '0;
            zero0_q     <= 1'b1;
            zero1_q     <= 1'b1;
            last_q      <= 1'b0;
            valid_a_q   <= 1'b0;
            cnt_q       <= '0;
            acc_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            addr0_q     <= addr0_d;
            addr1_q     <= addr1_d;
            sh0_q       <= sh0_d;
            sh1_q       <= sh1_d;
            zero0_q     <= zero0_d;
            zero1_q     <= zero1_d;
            last_q      <= last_d;
            valid_a_q   <= valid_a_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign address0  = addr0_q;
    assign address1  = addr1_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_lut_acc_seq.sv
// Scoreboard bench for lut_acc_seq with a behavioural odd-multiple LUT (word = ~(h*odd)).
// With LUT_ACC_OVF_EN defined, a second small instance exercises the ovf flag.
module tb_lut_acc_seq;

    localparam int TAPS  = 8;
    localparam int ACC_W = 24;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [7:0]       in_data = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [7:0]       address0, address1;
    logic [11:0]      memwrd0, memwrd1;
    logic [ACC_W-1:0] out_data;
    logic             out_valid;
    logic             out_ready = 1'b1;
`ifdef LUT_ACC_OVF_EN
    logic             ovf;
`endif

    logic [7:0]       h = 8'd5;
    int               n_checks = 0;
    int               n_fail = 0;
    int               model_cnt = 0;
    logic [ACC_W-1:0] model_acc = '0;
    logic [ACC_W-1:0] exp_q[$];
    logic [ACC_W-1:0] obs_q[$];
    logic [7:0]       enc_tbl [16] = '{8'h00, 8'h01, 8'h01, 8'h02, 8'h01, 8'h04, 8'h02, 8'h08,
                                       8'h01, 8'h10, 8'h04, 8'h20, 8'h02, 8'h40, 8'h08, 8'h80};

    always #5 clk = ~clk;

    lut_acc_seq #(.TAPS(TAPS), .ACC_W(ACC_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .address0  (address0),
        .address1  (address1),
        .memwrd0   (memwrd0),
        .memwrd1   (memwrd1),
        .out_data  (out_data),
        .out_valid (out_valid),
`ifdef LUT_ACC_OVF_EN
        .ovf       (ovf),
`endif
        .out_ready (out_ready)
    );

    function automatic logic [11:0] lut_word(input logic [7:0] a, input logic [7:0] hh);
        logic [11:0] w;
        int          p;
        w = 12'hFFF;
        for (int i = 0; i < 8; i++) begin
            if (a == (8'b1 << i)) begin
                p = int'(hh) * (2 * i + 1);
                w = ~p[11:0];
            end
        end
        return w;
    endfunction

    function automatic logic [ACC_W-1:0] prod(input logic [7:0] d, input logic [7:0] hh);
        int p;
        p = int'(d[3:0]) * int'(hh) + int'(d[7:4]) * int'(hh) * 16;
        return ACC_W'(p);
    endfunction

    always_comb memwrd0 = lut_word(address0, h);
    always_comb memwrd1 = lut_word(address1, h);

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) obs_q.push_back(out_data);
    end

    task automatic send(input logic [7:0] d);
        int guard;
        guard    = 0;
        in_data  = d;
        in_valid = 1'b1;
        while (!in_ready && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        n_checks++;
        if (guard >= 200) begin
            n_fail++;
            $display("FAIL send_timeout: in_ready stayed %b, required 1", in_ready);
        end
        model_acc = model_acc + prod(d, h);
        model_cnt++;
        if (model_cnt == TAPS) begin
            exp_q.push_back(model_acc);
            model_acc = '0;
            model_cnt = 0;
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_outputs();
        for (int i = 0; i < 100 && obs_q.size() < exp_q.size(); i++) begin
            @(posedge clk); #1;
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (address0 !== 8'h00 || address1 !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_addr: got %h/%h, required 00/00", address0, address1);
        end
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== '0) begin
            n_fail++;
            $display("FAIL reset_out: got valid=%b data=%0d, required 0/0", out_valid, out_data);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b, required 1", in_ready);
        end
`ifdef LUT_ACC_OVF_EN
        n_checks++;
        if (ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ovf: got %b, required 0", ovf);
        end
`endif
    endtask

    task automatic test_basic();
        logic [ACC_W-1:0] e, o;
        h = 8'h05;
        out_ready = 1'b1;
        for (int i = 0; i < TAPS; i++) send(8'hC3);
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_early: out_valid got %b one edge after last accept, required 0", out_valid);
        end
        @(posedge clk); #1;
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 24'd7800) begin
            n_fail++;
            $display("FAIL basic_result: got valid=%b data=%0d, required 1/7800", out_valid, out_data);
        end
`ifdef LUT_ACC_OVF_EN
        n_checks++;
        if (ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_ovf: got %b, required 0", ovf);
        end
`endif
        @(posedge clk); #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_pulse: out_valid got %b, required 0", out_valid);
        end
        wait_outputs();
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL basic_count: got %0d results, required %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL basic_data: got %0d, required %0d", o, e);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_encode_sweep();
        logic [ACC_W-1:0] e, o;
        logic [3:0]       lo, hi;
        h = 8'h07;
        out_ready = 1'b1;
        for (int n = 0; n < 16; n++) begin
            hi = 4'(n);
            lo = 4'(15 - n);
            send({hi, lo});
            n_checks++;
            if (address0 !== enc_tbl[15-n] || address1 !== enc_tbl[n]) begin
                n_fail++;
                $display("FAIL encode_addr n=%0d: got %h/%h, required %h/%h",
                         n, address0, address1, enc_tbl[15-n], enc_tbl[n]);
            end
        end
        in_valid = 1'b0;
        wait_outputs();
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL encode_count: got %0d results, required %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL encode_data: got %0d, required %0d", o, e);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_zero();
        logic [ACC_W-1:0] e, o;
        h = 8'h05;
        out_ready = 1'b1;
        for (int i = 0; i < TAPS; i++) begin
            send(8'h00);
            n_checks++;
            if (address0 !== 8'h00 || address1 !== 8'h00 || memwrd0 !== 12'hFFF) begin
                n_fail++;
                $display("FAIL zero_addr: got %h/%h word %h, required 00/00 word fff",
                         address0, address1, memwrd0);
            end
        end
        in_valid = 1'b0;
        wait_outputs();
        n_checks++;
        if (obs_q.size() != 1) begin
            n_fail++;
            $display("FAIL zero_count: got %0d results, required 1", obs_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o !== e || o !== '0) begin
                n_fail++;
                $display("FAIL zero_data: got %0d, required %0d", o, e);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_backpressure();
        logic [ACC_W-1:0] e, o, held;
        h = 8'h03;
        out_ready = 1'b0;
        for (int i = 0; i < TAPS; i++) send(8'(i * 17 + 1));
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        held = exp_q[0];
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== held) begin
            n_fail++;
            $display("FAIL bp_first: got valid=%b data=%0d, required 1/%0d", out_valid, out_data, held);
        end
        for (int i = 0; i < TAPS; i++) send(8'(i * 29 + 5));
        in_valid = 1'b0;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_ready_drop: in_ready got %b, required 0", in_ready);
        end
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== held) begin
            n_fail++;
            $display("FAIL bp_hold: got ready=%b valid=%b data=%0d, required 0/1/%0d",
                     in_ready, out_valid, out_data, held);
        end
        n_checks++;
        if (obs_q.size() != 0) begin
            n_fail++;
            $display("FAIL bp_leak: got %0d results while stalled, required 0", obs_q.size());
        end
        out_ready = 1'b1;
        for (int i = 0; i < TAPS; i++) send(8'hA5);
        in_valid = 1'b0;
        wait_outputs();
        n_checks++;
        if (obs_q.size() != 3 || exp_q.size() != 3) begin
            n_fail++;
            $display("FAIL bp_count: got %0d results, required 3 (model has %0d)", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL bp_data: got %0d, required %0d", o, e);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_reset_mid_window();
        logic [ACC_W-1:0] e, o;
        h = 8'h05;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) send(8'h77);
        in_valid = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || address0 !== 8'h00) begin
            n_fail++;
            $display("FAIL midrst_state: got valid=%b addr0=%h, required 0/00", out_valid, address0);
        end
        model_acc = '0;
        model_cnt = 0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        h = 8'h01;
        for (int i = 0; i < TAPS; i++) send(8'h01);
        in_valid = 1'b0;
        wait_outputs();
        n_checks++;
        if (obs_q.size() != 1) begin
            n_fail++;
            $display("FAIL midrst_count: got %0d results, required 1", obs_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o !== e || o !== 24'd8) begin
                n_fail++;
                $display("FAIL midrst_data: got %0d, required 8 (model %0d)", o, e);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

`ifdef LUT_ACC_OVF_EN
    logic [7:0]  o_in_data = '0;
    logic        o_in_valid = 1'b0;
    logic        o_in_ready, o_out_valid, o_ovf;
    logic [7:0]  o_addr0, o_addr1;
    logic [18:0] o_out_data;
    logic [11:0] o_word = 12'h000;

    lut_acc_seq #(.TAPS(2), .ACC_W(19)) dut_ovf (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (o_in_data),
        .in_valid  (o_in_valid),
        .in_ready  (o_in_ready),
        .address0  (o_addr0),
        .address1  (o_addr1),
        .memwrd0   (o_word),
        .memwrd1   (o_word),
        .out_data  (o_out_data),
        .out_valid (o_out_valid),
        .ovf       (o_ovf),
        .out_ready (1'b1)
    );

    task automatic test_ovf();
        logic [7:0]  samp [2] = '{8'h88, 8'hFF};
        logic [18:0] exp_d [2] = '{19'd65264, 19'd139230};
        logic        exp_o [2] = '{1'b1, 1'b0};
        for (int w = 0; w < 2; w++) begin
            for (int s = 0; s < 2; s++) begin
                o_in_data  = samp[w];
                o_in_valid = 1'b1;
                n_checks++;
                if (o_in_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL ovf_ready: got %b, required 1", o_in_ready);
                end
                @(posedge clk); #1;
            end
            o_in_valid = 1'b0;
            @(posedge clk); #1;
            n_checks++;
            if (o_out_valid !== 1'b1 || o_out_data !== exp_d[w] || o_ovf !== exp_o[w]) begin
                n_fail++;
                $display("FAIL ovf_result w=%0d: got valid=%b data=%0d ovf=%b, required 1/%0d/%b",
                         w, o_out_valid, o_out_data, o_ovf, exp_d[w], exp_o[w]);
            end
            @(posedge clk); #1;
        end
    endtask
`endif

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_encode_sweep();
        test_zero();
        test_backpressure();
`ifdef LUT_ACC_OVF_EN
        test_ovf();
`endif
        test_reset_mid_window();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
